// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: response codes, write/read FSM states and data width shared by the AXI-Lite register slave
package axi_lite_pkg;
    localparam int AXI_DATA_W = 32;
    typedef logic [1:0] resp_t;
    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
    typedef enum logic [1:0] {W_IDLE, W_GOT_ADDR, W_GOT_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;
endpackage

// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile: NUM_REGS x 32-bit registers, one byte-enabled write port, one asynchronous read port
module axi_lite_regfile import axi_lite_pkg::*; #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [AXI_DATA_W-1:0] wdata,
    input  logic [3:0]            wstrb,
    input  logic [IDX_W-1:0]      ridx,
    output logic [AXI_DATA_W-1:0] rdata
);
    logic [AXI_DATA_W-1:0] regs_q [NUM_REGS];
    logic [AXI_DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++)
            for (int b = 0; b < 4; b++)
                if (we && wstrb[b] && widx == IDX_W'(i)) regs_d[i][8*b +: 8] = wdata[8*b +: 8];
    end

    // unmatched indices read as zero
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (ridx == IDX_W'(i)) rdata = regs_q[i];
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) regs_q <= '{default: '0};
        else     regs_q <= regs_d;
endmodule

// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave: AXI4-Lite slave over NUM_REGS 32-bit registers with independent read/write FSMs.
// Define AXI_SLV_ERR_RESP_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi_lite_reg_slave import axi_lite_pkg::*; #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready
);
    localparam int IW = ADDR_WIDTH - 2;
`ifdef AXI_SLV_ERR_RESP_EN
    localparam resp_t OOR_RESP = RESP_SLVERR;
`else
    localparam resp_t OOR_RESP = RESP_OKAY;
`endif

    w_state_e              w_q, w_d;
    r_state_e              r_q, r_d;
    logic                  rdy_q, rdy_d;
    logic [IW-1:0]         waddr_q, waddr_d, c_idx, r_idx;
    logic [DATA_WIDTH-1:0] wdat_q, wdat_d, c_data, rf_rdata, rdata_q, rdata_d;
    logic [3:0]            wstrb_q, wstrb_d, c_strb;
    resp_t                 bresp_q, bresp_d, rresp_q, rresp_d;
    logic                  aw_hs, w_hs, ar_hs, commit, c_ok, r_ok, unused_addr_bits;

    // rdy_q holds all readies low until the first edge after reset release
    assign awready = rdy_q && (w_q == W_IDLE || w_q == W_GOT_DATA);
    assign wready  = rdy_q && (w_q == W_IDLE || w_q == W_GOT_ADDR);
    assign arready = rdy_q && r_q == R_IDLE;
    assign bvalid  = w_q == W_RESP;
    assign rvalid  = r_q == R_DATA;
    assign bresp   = bresp_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;
    assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

    always_comb begin
        rdy_d   = 1'b1;
        aw_hs   = awvalid && awready;
        w_hs    = wvalid && wready;
        ar_hs   = arvalid && arready;
        c_idx   = (w_q == W_GOT_ADDR) ? waddr_q : awaddr[ADDR_WIDTH-1:2];
        c_data  = (w_q == W_GOT_DATA) ? wdat_q : wdata;
        c_strb  = (w_q == W_GOT_DATA) ? wstrb_q : wstrb;
        c_ok    = 32'(c_idx) < NUM_REGS;
        commit  = (aw_hs || w_q == W_GOT_ADDR) && (w_hs || w_q == W_GOT_DATA);
        waddr_d = aw_hs ? awaddr[ADDR_WIDTH-1:2] : waddr_q;
        wdat_d  = w_hs ? wdata : wdat_q;
        wstrb_d = w_hs ? wstrb : wstrb_q;
        bresp_d = commit ? (c_ok ? RESP_OKAY : OOR_RESP) : bresp_q;
        w_d     = commit                       ? W_RESP     :
                  (w_q == W_IDLE && aw_hs)     ? W_GOT_ADDR :
                  (w_q == W_IDLE && w_hs)      ? W_GOT_DATA :
                  (w_q == W_RESP && bready)    ? W_IDLE     : w_q;
        r_idx   = araddr[ADDR_WIDTH-1:2];
        r_ok    = 32'(r_idx) < NUM_REGS;
        rdata_d = ar_hs ? (r_ok ? rf_rdata : '0) : rdata_q;
        rresp_d = ar_hs ? (r_ok ? RESP_OKAY : OOR_RESP) : rresp_q;
        r_d     = ar_hs ? R_DATA : (r_q == R_DATA && rready) ? R_IDLE : r_q;
    end

    axi_lite_regfile #(.NUM_REGS(NUM_REGS), .IDX_W(IW)) u_regs (
        .clk   (aclk),
        .rst   (areset),
        .we    (commit && c_ok),
        .widx  (c_idx),
        .wdata (c_data),
        .wstrb (c_strb),
        .ridx  (r_idx),
        .rdata (rf_rdata)
    );

    always_ff @(posedge aclk or posedge areset)
        if (areset) begin
            w_q     <= W_IDLE;
            r_q     <= R_IDLE;
            rdy_q   <= 1'b0;
            waddr_q <= '0;
            wdat_q  <= '0;
            wstrb_q <= '0;
            bresp_q <= RESP_OKAY;
            rresp_q <= RESP_OKAY;
            rdata_q <= '0;
        end else begin
            w_q     <= w_d;
            r_q     <= r_d;
            rdy_q   <= rdy_d;
            waddr_q <= waddr_d;
            wdat_q  <= wdat_d;
            wstrb_q <= wstrb_d;
            bresp_q <= bresp_d;
            rresp_q <= rresp_d;
            rdata_q <= rdata_d;
        end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// tb_axi_lite_reg_slave: randomized AXI-Lite traffic checked against an array model of the register file
module tb_axi_lite_reg_slave;
`ifdef AXI_SLV_ERR_RESP_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif
    logic        aclk = 1'b0, areset = 1'b1;
    logic [7:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [31:0] mem [16];
    int          vectors = 0, errors = 0;

    axi_lite_reg_slave dut (
        .aclk(aclk), .areset(areset),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int which);
        return which == 0 ? awready : which == 1 ? wready : which == 2 ? (awready && wready) : arready;
    endfunction

    task automatic wait_rdy(input string tag, input int which);
        int n = 0;
        while (!rdy(which) && n < 50) begin
            @(negedge aclk);
            n++;
        end
        if (n == 50) check({tag, "_timeout"}, 0, 1);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [7:0] a);
        return (a >> 2) < 16 ? 2'b00 : OOR;
    endfunction

    // mode 0: AW+W together, 1: AW first, 2: W first; gap idle cycles between them
    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int mode, input int gap, input int bdly);
        if (mode == 0) begin
            awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
            wait_rdy("aw_w", 2);
            @(negedge aclk); awvalid = 0; wvalid = 0;
        end else if (mode == 1) begin
            awaddr = a; awvalid = 1;
            wait_rdy("aw", 0);
            @(negedge aclk); awvalid = 0;
            repeat (gap + 1) begin
                check("got_addr_rdy", {awready, wready}, 2'b01);
                @(negedge aclk);
            end
            wdata = d; wstrb = s; wvalid = 1;
            wait_rdy("w", 1);
            @(negedge aclk); wvalid = 0;
        end else begin
            wdata = d; wstrb = s; wvalid = 1;
            wait_rdy("w", 1);
            @(negedge aclk); wvalid = 0;
            repeat (gap + 1) begin
                check("got_data_rdy", {awready, wready}, 2'b10);
                @(negedge aclk);
            end
            awaddr = a; awvalid = 1;
            wait_rdy("aw", 0);
            @(negedge aclk); awvalid = 0;
        end
        if ((a >> 2) < 16) mem[a >> 2] = merge(mem[a >> 2], d, s);
        check("bvalid", bvalid, 1);
        check("bresp", bresp, exp_resp(a));
        awaddr = 8'($urandom_range(0, 63)); awvalid = 1;
        repeat (bdly) begin
            @(negedge aclk);
            check("bvalid_hold", bvalid, 1);
            check("bresp_hold", bresp, exp_resp(a));
            check("rdy_in_resp", {awready, wready}, 2'b00);
        end
        bready = 1;
        @(negedge aclk);
        bready = 0; awvalid = 0;
        check("bvalid_clr", bvalid, 0);
        check("aw_rdy_after_b", awready, 1);
    endtask

    task automatic do_read(input logic [7:0] a, input int rdly);
        logic [31:0] e = (a >> 2) < 16 ? mem[a >> 2] : 32'h0;
        araddr = a; arvalid = 1;
        wait_rdy("ar", 3);
        @(negedge aclk); arvalid = 0;
        check("rvalid", rvalid, 1);
        check("rdata", rdata, e);
        check("rresp", rresp, exp_resp(a));
        repeat (rdly) begin
            @(negedge aclk);
            check("rdata_hold", {rvalid, arready, rdata}, {2'b10, e});
        end
        rready = 1;
        @(negedge aclk);
        rready = 0;
        check("rvalid_clr", rvalid, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        #1;
        check("rst_outs", {awready, wready, arready, bvalid, rvalid, bresp, rresp}, 0);
        check("rst_rdata", rdata, 0);
        repeat (3) @(negedge aclk);
        check("rst_rdy_held", {awready, wready, arready}, 0);
        areset = 0;
        #1 check("rdy_before_edge", {awready, wready, arready}, 0);
        @(negedge aclk);
        check("rdy_after_edge", {awready, wready, arready}, 3'b111);

        do_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_read(8'h04, 0);
        do_write(8'h08, 32'hAABBCCDD, 4'hF, 0, 0, 0);
        do_write(8'h08, 32'h11223344, 4'h3, 2, 2, 0);
        do_read(8'h08, 1);
        check("model_merge", mem[2], 32'hAABB3344);
        do_write(8'h10, 32'h0BADF00D, 4'hF, 1, 1, 5);
        do_write(8'h14, 32'hFFFFFFFF, 4'h0, 0, 0, 1);
        do_read(8'h14, 0);
        do_write(8'h40, 32'h12345678, 4'hF, 0, 0, 0);
        do_read(8'h40, 2);

        do_write(8'h0C, 32'h1, 4'hF, 0, 0, 0);
        awaddr = 8'h0C; wdata = 32'h5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 8'h0C; arvalid = 1;
        wait_rdy("rw", 2);
        @(negedge aclk); awvalid = 0; wvalid = 0; arvalid = 0;
        check("same_cycle_old", rdata, 32'h1);
        check("same_cycle_b", bvalid, 1);
        mem[3] = 32'h5;
        bready = 1; rready = 1;
        @(negedge aclk); bready = 0; rready = 0;
        do_read(8'h0C, 0);

        for (int n = 0; n < 150; n++) begin
            logic [7:0] a = 8'($urandom_range(0, 79));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)));
            else
                do_read(a, int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 17; i++) do_read(8'(i * 4), 0);

        do_write(8'h18, 32'hCAFE0001, 4'hF, 0, 0, 0);
        awaddr = 8'h1C; wdata = 32'h77; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 8'h18; arvalid = 1;
        wait_rdy("rst_flight", 2);
        @(negedge aclk); awvalid = 0; wvalid = 0; arvalid = 0;
        check("inflight_valids", {bvalid, rvalid}, 2'b11);
        #2 areset = 1;
        #1 check("async_rst_outs", {bvalid, rvalid, awready, wready, arready, bresp, rresp}, 0);
        check("async_rst_rdata", rdata, 0);
        @(negedge aclk); areset = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        @(negedge aclk);
        check("post_rst_valids", {bvalid, rvalid}, 0);
        for (int i = 0; i < 16; i++) do_read(8'(i * 4), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
